// File: rtl/nx_fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// nx_fifo_rd_stream
//
// Read-side drain engine for an nx_fifo. It watches the FIFO empty flag and
// fill level, pulls words with fifo_ren against the FIFO's combinational
// rdata, and presents them on a registered valid/ready stream through a
// two-entry (head + skid) output buffer. Draining starts once the fill level
// reaches cfg_threshold, or at once while flush is high.
//
// Ports:
//   clk             - sole clock
//   rst_n           - synchronous active-low reset
//   fifo_empty      - FIFO empty flag
//   fifo_used_slots - FIFO fill level
//   fifo_rdata      - FIFO read data, valid in the same cycle while not empty
//   fifo_ren        - FIFO read enable
//   out_valid       - stream valid (buffer not empty)
//   out_ready       - stream ready from the consumer
//   out_data        - stream data (head entry, zero when not valid)
//   out_last        - head word was the only FIFO entry when it was read
//   cfg_threshold   - fill level that starts a drain (quasi-static)
//   flush           - level input: drain regardless of threshold
//   clear           - synchronous discard of buffered words, back to IDLE
//   buf_cnt         - output buffer occupancy, 0..2
// -----------------------------------------------------------------------------
module nx_fifo_rd_stream #(
  parameter int WIDTH  = 83,
  parameter int USED_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_empty,
  input  logic [USED_W-1:0] fifo_used_slots,
  input  logic [WIDTH-1:0]  fifo_rdata,
  output logic              fifo_ren,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_last,
  input  logic [USED_W-1:0] cfg_threshold,
  input  logic              flush,
  input  logic              clear,
  output logic [1:0]        buf_cnt
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   head_data_q, head_data_d;
  logic               head_last_q, head_last_d;
  logic [WIDTH-1:0]   skid_data_q, skid_data_d;
  logic               skid_last_q, skid_last_d;

  logic               push_s;
  logic               pop_s;
  logic               in_last_s;
  logic               start_s;

  localparam logic [USED_W-1:0] USED_ONE = {{(USED_W-1){1'b0}}, 1'b1};

  // A threshold of zero would be met by an empty FIFO, so the compare is
  // additionally gated by fifo_empty; flush starts a drain unconditionally.
  assign start_s = flush | (~fifo_empty & (fifo_used_slots >= cfg_threshold));

  // Read only while draining, with room in the buffer. The buffer room check
  // uses the registered count, so out_ready never reaches fifo_ren. rst_n is
  // included so no read is issued while reset is being applied.
  assign fifo_ren = (state_q == ST_DRAIN) & ~fifo_empty & (cnt_q != 2'd2)
                    & ~clear & rst_n;

  assign push_s    = fifo_ren;
  assign pop_s     = (cnt_q != 2'd0) & out_ready;
  assign in_last_s = (fifo_used_slots == USED_ONE);

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = head_data_q;
  assign out_last  = head_last_q;
  assign buf_cnt   = cnt_q;

  // Drain FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_s) state_d = ST_DRAIN;
        else         state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        // flush keeps the engine armed even while the FIFO is momentarily empty
        if (fifo_empty && !flush) state_d = ST_IDLE;
        else                      state_d = ST_DRAIN;
      end
      default: state_d = ST_IDLE;
    endcase
    if (clear) state_d = ST_IDLE;
    else       state_d = state_d;
  end

  // Output buffer next-state: unoccupied entries are always held at zero.
  always_comb begin
    cnt_d       = cnt_q;
    head_data_d = head_data_q;
    head_last_d = head_last_q;
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;
    if (clear) begin
      cnt_d       = 2'd0;
      head_data_d = {WIDTH{1'b0}};
      head_last_d = 1'b0;
      skid_data_d = {WIDTH{1'b0}};
      skid_last_d = 1'b0;
    end else begin
      case (cnt_q)
        2'd0: begin
          if (push_s) begin
            head_data_d = fifo_rdata;
            head_last_d = in_last_s;
            cnt_d       = 2'd1;
          end else begin
            cnt_d = 2'd0;
          end
        end
        2'd1: begin
          if (push_s && pop_s) begin
            head_data_d = fifo_rdata;
            head_last_d = in_last_s;
          end else if (push_s) begin
            skid_data_d = fifo_rdata;
            skid_last_d = in_last_s;
            cnt_d       = 2'd2;
          end else if (pop_s) begin
            head_data_d = {WIDTH{1'b0}};
            head_last_d = 1'b0;
            cnt_d       = 2'd0;
          end else begin
            cnt_d = 2'd1;
          end
        end
        2'd2: begin
          // fifo_ren is blocked at count 2, so only a pop can happen here
          if (pop_s) begin
            head_data_d = skid_data_q;
            head_last_d = skid_last_q;
            skid_data_d = {WIDTH{1'b0}};
            skid_last_d = 1'b0;
            cnt_d       = 2'd1;
          end else begin
            cnt_d = 2'd2;
          end
        end
        default: begin
          cnt_d       = 2'd0;
          head_data_d = {WIDTH{1'b0}};
          head_last_d = 1'b0;
          skid_data_d = {WIDTH{1'b0}};
          skid_last_d = 1'b0;
        end
      endcase
    end
  end

  // State and buffer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 2'd0;
      head_data_q <= {WIDTH{1'b0}};
      head_last_q <= 1'b0;
      skid_data_q <= {WIDTH{1'b0}};
      skid_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      head_data_q <= head_data_d;
      head_last_q <= head_last_d;
      skid_data_q <= skid_data_d;
      skid_last_q <= skid_last_d;
    end
  end

endmodule

// File: tb/tb_nx_fifo_rd_stream.sv
// Self-checking bench for nx_fifo_rd_stream. A behavioural FIFO model feeds
// the DUT; written words go into a scoreboard queue and are compared when the
// DUT transfers them. The FIFO model updates its outputs 1 ns after the clock.
module tb_nx_fifo_rd_stream;
  localparam int WIDTH  = 83;
  localparam int USED_W = 5;

  logic              clk;
  logic              rst_n;
  logic              fifo_empty;
  logic [USED_W-1:0] fifo_used_slots;
  logic [WIDTH-1:0]  fifo_rdata;
  logic              fifo_ren;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic              out_last;
  logic [USED_W-1:0] cfg_threshold;
  logic              flush;
  logic              clear;
  logic [1:0]        buf_cnt;

  nx_fifo_rd_stream #(.WIDTH(WIDTH), .USED_W(USED_W)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty),
    .fifo_used_slots(fifo_used_slots), .fifo_rdata(fifo_rdata),
    .fifo_ren(fifo_ren), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .cfg_threshold(cfg_threshold),
    .flush(flush), .clear(clear), .buf_cnt(buf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ren_cnt = 0;
  int delivered = 0;
  int mdl_cnt = 0;

  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] exp_q[$];
  logic             last_q[$];

  logic             pend_ren, pend_wr, pend_pop, pend_rst, pend_clr;
  logic [WIDTH-1:0] pend_wdata;
  logic             prev_hold;
  logic [WIDTH-1:0] prev_data;
  logic             prev_last;

  typedef struct {
    logic [USED_W-1:0] thr;
    int                nwords;
    logic              flush;
    int                exp_ren;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Negedge: sample DUT outputs, compare against the scoreboard.
  task automatic monitor_sample();
    logic exp_last;
    pend_ren   = fifo_ren;
    pend_wr    = wr_en;
    pend_wdata = wr_data;
    pend_pop   = out_valid & out_ready;
    pend_rst   = ~rst_n;
    pend_clr   = clear;
    if (fifo_ren) ren_cnt++;
    chk("buf_cnt_model", 128'(buf_cnt), 128'(mdl_cnt));
    if (prev_hold) begin
      chk("stall_valid", 128'(out_valid), 128'd1);
      chk("stall_data", 128'(out_data), 128'(prev_data));
      chk("stall_last", 128'(out_last), 128'(prev_last));
    end
    if (rst_n && !clear) begin
      if (!out_valid) chk("idle_data_zero", 128'({out_last, out_data}), 128'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0 || last_q.size() == 0) begin
          chk("unexpected_word", 128'(exp_q.size()), 128'd1);
        end else begin
          exp_last = last_q.pop_front();
          chk("sb_data", 128'(out_data), 128'(exp_q.pop_front()));
          chk("sb_last", 128'(out_last), 128'(exp_last));
        end
        delivered++;
      end
    end else begin
      for (int i = 0; i < mdl_cnt; i++) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        if (last_q.size() != 0) void'(last_q.pop_front());
      end
    end
    prev_hold = rst_n & ~clear & out_valid & ~out_ready;
    prev_data = out_data;
    prev_last = out_last;
  endtask

  // Posedge + 1: FIFO model applies the read and write of the finished cycle.
  task automatic model_update();
    if (pend_ren) begin
      chk("no_underflow", 128'(fifo_q.size() != 0), 128'd1);
      if (fifo_q.size() != 0) begin
        last_q.push_back(fifo_q.size() == 1);
        void'(fifo_q.pop_front());
      end
    end
    if (pend_wr) fifo_q.push_back(pend_wdata);
    if (pend_rst || pend_clr) mdl_cnt = 0;
    else mdl_cnt = mdl_cnt + int'(pend_ren) - int'(pend_pop);
    fifo_empty      = (fifo_q.size() == 0);
    fifo_used_slots = USED_W'(fifo_q.size());
    fifo_rdata      = (fifo_q.size() == 0) ? {WIDTH{1'b0}} : fifo_q[0];
  endtask

  task automatic tick();
    @(negedge clk);
    monitor_sample();
    @(posedge clk);
    #1;
    model_update();
    #1;
  endtask

  task automatic push_word();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    wr_en   = 1'b1;
    wr_data = r[WIDTH-1:0];
    exp_q.push_back(wr_data);
  endtask

  task automatic drain(input logic use_flush);
    int n = 0;
    flush = use_flush;
    out_ready = 1'b1;
    wr_en = 1'b0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0 || mdl_cnt != 0) && n < 200) begin
      tick();
      n++;
    end
    flush = 1'b0;
    tick();
    tick();
    chk("drain_done", 128'(exp_q.size()), 128'd0);
  endtask

  initial begin
    int r0;
    int d0;
    int written;
    int cyc;
    vecs[0] = '{5'd4,  3, 1'b0, 0};
    vecs[1] = '{5'd4,  4, 1'b0, 4};
    vecs[2] = '{5'd0,  0, 1'b0, 0};
    vecs[3] = '{5'd0,  1, 1'b0, 1};
    vecs[4] = '{5'd10, 2, 1'b1, 2};
    vecs[5] = '{5'd1,  5, 1'b0, 5};
    vecs[6] = '{5'd3,  2, 1'b0, 0};
    vecs[7] = '{5'd2,  2, 1'b0, 2};

    rst_n = 1'b0; clear = 1'b0; flush = 1'b0; out_ready = 1'b0;
    cfg_threshold = '0; wr_en = 1'b0; wr_data = '0;
    fifo_empty = 1'b1; fifo_used_slots = '0; fifo_rdata = '0;
    pend_ren = 1'b0; pend_wr = 1'b0; pend_pop = 1'b0; pend_rst = 1'b1; pend_clr = 1'b0;
    pend_wdata = '0; prev_hold = 1'b0; prev_data = '0; prev_last = 1'b0;

    // Reset
    repeat (3) begin
      #1 chk("ren_in_reset", 128'(fifo_ren), 128'd0);
      tick();
    end
    rst_n = 1'b1;
    #1;
    chk("rst_valid", 128'(out_valid), 128'd0);
    chk("rst_data", 128'(out_data), 128'd0);
    chk("rst_last", 128'(out_last), 128'd0);
    chk("rst_buf_cnt", 128'(buf_cnt), 128'd0);
    chk("rst_ren", 128'(fifo_ren), 128'd0);
    tick();
    chk("ren_after_rst", 128'(fifo_ren), 128'd0);

    // Threshold accumulate latency: 4 words, threshold 4
    cfg_threshold = 5'd4;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_word();
      chk("acc_ren_hold", 128'(fifo_ren), 128'd0);
      tick();
    end
    wr_en = 1'b0;
    chk("acc_used", 128'(fifo_used_slots), 128'd4);
    chk("acc_ren_N", 128'(fifo_ren), 128'd0);
    tick();
    chk("acc_ren_N1", 128'(fifo_ren), 128'd1);
    chk("acc_valid_N1", 128'(out_valid), 128'd0);
    tick();
    chk("acc_valid_N2", 128'(out_valid), 128'd1);
    chk("acc_last_D0", 128'(out_last), 128'd0);
    drain(1'b0);

    // Threshold / flush vector table
    for (int v = 0; v < 8; v++) begin
      cfg_threshold = vecs[v].thr;
      out_ready = 1'b1;
      r0 = ren_cnt;
      for (int i = 0; i < vecs[v].nwords; i++) begin
        push_word();
        tick();
      end
      wr_en = 1'b0;
      if (vecs[v].flush) begin
        flush = 1'b1;
        tick();
        flush = 1'b0;
      end
      repeat (6) tick();
      chk($sformatf("vec%0d_ren_count", v), 128'(ren_cnt - r0), 128'(vecs[v].exp_ren));
      drain(1'b1);
    end

    // Backpressure: 8 words, consumer stalled
    cfg_threshold = 5'd1;
    out_ready = 1'b0;
    r0 = ren_cnt;
    for (int i = 0; i < 8; i++) begin
      push_word();
      tick();
    end
    wr_en = 1'b0;
    repeat (6) tick();
    chk("bp_ren_count", 128'(ren_cnt - r0), 128'd2);
    chk("bp_buf_cnt", 128'(buf_cnt), 128'd2);
    chk("bp_used", 128'(fifo_used_slots), 128'd6);
    chk("bp_valid", 128'(out_valid), 128'd1);
    d0 = delivered;
    out_ready = 1'b1;
    #1 chk("bp_ren_pop_cycle", 128'(fifo_ren), 128'd0);
    tick();
    chk("bp_ren_restart", 128'(fifo_ren), 128'd1);
    drain(1'b0);
    chk("bp_delivered", 128'(delivered - d0), 128'd8);

    // Clear with a full buffer, pop offered in the same cycle
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push_word();
      tick();
    end
    wr_en = 1'b0;
    repeat (6) tick();
    chk("clr_pre_buf_cnt", 128'(buf_cnt), 128'd2);
    d0 = delivered;
    out_ready = 1'b1;
    clear = 1'b1;
    #1 chk("clr_ren", 128'(fifo_ren), 128'd0);
    tick();
    clear = 1'b0;
    #1;
    chk("clr_valid", 128'(out_valid), 128'd0);
    chk("clr_buf_cnt", 128'(buf_cnt), 128'd0);
    chk("clr_data", 128'(out_data), 128'd0);
    chk("clr_ren_idle", 128'(fifo_ren), 128'd0);
    chk("clr_used_kept", 128'(fifo_used_slots), 128'd6);
    tick();
    chk("clr_restart_ren", 128'(fifo_ren), 128'd1);
    drain(1'b0);
    chk("clr_delivered", 128'(delivered - d0), 128'd6);

    // Reset in the middle of a drain
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push_word();
      tick();
    end
    wr_en = 1'b0;
    chk("mrst_pre_buf_cnt", 128'(buf_cnt), 128'd1);
    rst_n = 1'b0;
    #1 chk("mrst_ren_during", 128'(fifo_ren), 128'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("mrst_valid", 128'(out_valid), 128'd0);
    chk("mrst_data", 128'(out_data), 128'd0);
    chk("mrst_last", 128'(out_last), 128'd0);
    chk("mrst_buf_cnt", 128'(buf_cnt), 128'd0);
    chk("mrst_ren_after", 128'(fifo_ren), 128'd0);
    drain(1'b0);

    // Random consumer stalls with concurrent FIFO writes
    cfg_threshold = 5'd2;
    written = 0;
    cyc = 0;
    while (written < 1000 && cyc < 20000) begin
      out_ready = 1'($urandom_range(0, 1));
      if (fifo_q.size() < 28 && $urandom_range(0, 9) < 6) begin
        push_word();
        written++;
      end else begin
        wr_en = 1'b0;
      end
      tick();
      cyc++;
    end
    chk("rand_written", 128'(written), 128'd1000);
    drain(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
